// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: holds the fetch address, advances it each fetch,
// applies jump/branch redirects (buffering one across imem stalls) and squashes IF/ID.
module fetch_pc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        imem_stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic        redirect_err,
  input  logic        halt,
  output logic [15:0] PC,
  output logic [15:0] PC_plus_two,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pend_target;

  function automatic logic redirect_illegal(input logic [15:0] target,
                                            input logic        target_err);
    return target_err | target[0];
  endfunction

  assign PC_plus_two = PC + 16'd2;
  assign fetch_valid = (state == RUN) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      PC          <= 16'h0000;
      pend_target <= 16'h0000;
      flush       <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      flush <= 1'b0;
      unique case (state)
        RUN: begin
          // A redirect outranks halt and stall: both belong to younger, wrong-path work.
          if (redirect_valid) begin
            if (redirect_illegal(redirect_target, redirect_err)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              flush <= 1'b1;
              if (imem_stall) begin
                pend_target <= redirect_target;
                state       <= HOLD;
              end else begin
                PC <= redirect_target;
              end
            end
          end else if (halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!stall && !imem_stall) begin
            if (PC == 16'hFFFE) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              PC <= PC_plus_two;
            end
          end
        end
        HOLD: begin
          // Oldest redirect wins; everything else waits for imem.
          if (!imem_stall) begin
            PC    <= pend_target;
            state <= RUN;
          end
        end
        HALT: state <= HALT;
        ERR:  state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule
